// File: rtl/data_mem_responder.sv
// Load/store responder around a word-wide single-port RAM without byte enables.
// Narrow stores are read-modify-write; loads are lane-extracted and sign/zero-extended.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RESP_VALID,
  output logic [31:0]           RESP_RDATA,
  output logic                  RESP_ERR
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LD,
    S_MRG,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  // MRG spans two cycles: the first registers the merged word, the second writes it.
  logic                  mrg_ph_q;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0]           rd_word_q;
  logic [31:0]           wr_word_q;

  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : {32{1'bx}})};

  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_fmt;
  logic [31:0]      merged;

  assign REQ_READY  = (state_q == S_IDLE);
  assign accept     = REQ_VALID && REQ_READY;
  assign RESP_VALID = resp_valid_q;
  assign RESP_RDATA = resp_rdata_q;
  assign RESP_ERR   = resp_err_q;

  assign idx  = addr_q[ADDR_WIDTH-1:2];
  assign lane = addr_q[1:0];

  always_comb begin
    req_err = 1'b0;
    case (REQ_SIZE)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = REQ_ADDR[0];
      SZ_WORD: req_err = (REQ_ADDR[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_err ? S_ERR : S_RD;
        end
      end
      S_RD:  state_d = we_q ? S_MRG : S_LD;
      S_LD:  state_d = S_IDLE;
      S_MRG: begin
        if (mrg_ph_q) begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_sel = rd_word_q[{lane, 3'b000} +: 8];
    half_sel = rd_word_q[{lane[1], 4'b0000} +: 16];
    load_fmt = rd_word_q;
    case (size_q)
      SZ_BYTE: load_fmt = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_fmt = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_fmt = rd_word_q;
    endcase
  end

  always_comb begin
    merged = rd_word_q;
    case (size_q)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wdata_q[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      mrg_ph_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mrg_ph_q     <= (state_q == S_MRG) && !mrg_ph_q;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      case (state_q)
        S_LD: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_fmt;
        end
        S_MRG: begin
          resp_valid_q <= mrg_ph_q;
        end
        S_ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request fields need no reset: they are only consumed after an accept reloads them.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= REQ_WE;
      size_q  <= REQ_SIZE;
      uns_q   <= REQ_UNSIGNED;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
    end
    if (state_q == S_MRG && !mrg_ph_q) begin
      wr_word_q <= merged;
    end
  end

  // Single RAM port: reads only in RD, writes only in the second MRG cycle.
  always_ff @(posedge CLK) begin
    if (state_q == S_RD) begin
      rd_word_q <= mem_q[idx];
    end
    if (!RST && state_q == S_MRG && mrg_ph_q) begin
      mem_q[idx] <= wr_word_q;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, back-to-back and reset-abort sequences,
// then random traffic checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [11:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_responder #(.ADDR_WIDTH(12), .INIT_ZERO(1'b1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_WE       (REQ_WE),
    .REQ_SIZE     (REQ_SIZE),
    .REQ_UNSIGNED (REQ_UNSIGNED),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .RESP_VALID   (RESP_VALID),
    .RESP_RDATA   (RESP_RDATA),
    .RESP_ERR     (RESP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference memory: plain byte array, little-endian.
  logic [7:0] ref_mem [4096];

  function automatic void model_txn(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [11:0] addr, input logic [31:0] wdata,
                                    output logic err, output logic [31:0] rdata,
                                    output int lat);
    int nbytes;
    logic [31:0] val;
    nbytes = 1 << size;
    err    = (size == 2'd3) || ((int'(addr) % nbytes) != 0);
    rdata  = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      lat = 3;
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_mem[int'(addr) + i]) << (8*i));
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~((32'h1 << (8*nbytes)) - 32'h1);
      rdata = val;
      lat   = 2;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (REQ_READY !== 1'b1 && w < 10) begin
      @(posedge CLK); #1;
      w++;
    end
    check("ready_wait", 32'(REQ_READY), 32'h1);
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata);
    REQ_WE       = we;
    REQ_SIZE     = size;
    REQ_UNSIGNED = uns;
    REQ_ADDR     = addr;
    REQ_WDATA    = wdata;
    REQ_VALID    = 1'b1;
  endtask

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata, output int lat);
    wait_ready();
    drive(we, size, uns, addr, wdata);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    lat   = 0;
    err   = 1'b0;
    rdata = 32'h0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge CLK); #1;
      if (RESP_VALID === 1'b1) begin
        lat   = c;
        err   = RESP_ERR;
        rdata = RESP_RDATA;
      end
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%03h wdata=%08h -> err=%0d rdata=%08h lat=%0d",
             we, size, uns, addr, wdata, err, rdata, lat);
    if (lat == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: got no RESP_VALID expected a response");
    end else begin
      @(posedge CLK); #1;
      check("resp_pulse", 32'(RESP_VALID), 32'h0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic exp_err, input logic [31:0] exp_rdata,
                              input int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        g_err, m_err;
    logic [31:0] g_rd, m_rd;
    int          g_lat, m_lat;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

    vecs.push_back(mk(1, 2, 0, 12'h010, 32'hDEADBEEF, 0, 32'h0,        3));
    vecs.push_back(mk(0, 2, 0, 12'h010, 32'h0,        0, 32'hDEADBEEF, 2));
    vecs.push_back(mk(0, 0, 0, 12'h011, 32'h0,        0, 32'hFFFFFFBE, 2));
    vecs.push_back(mk(0, 0, 1, 12'h011, 32'h0,        0, 32'h000000BE, 2));
    vecs.push_back(mk(0, 0, 0, 12'h013, 32'h0,        0, 32'hFFFFFFDE, 2));
    vecs.push_back(mk(1, 1, 0, 12'h012, 32'h00001234, 0, 32'h0,        3));
    vecs.push_back(mk(0, 2, 0, 12'h010, 32'h0,        0, 32'h1234BEEF, 2));
    vecs.push_back(mk(1, 0, 0, 12'h010, 32'h00000077, 0, 32'h0,        3));
    vecs.push_back(mk(0, 2, 0, 12'h010, 32'h0,        0, 32'h1234BE77, 2));
    vecs.push_back(mk(0, 2, 0, 12'h013, 32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 12'h011, 32'h0,        1, 32'h0,        1));
    vecs.push_back(mk(1, 3, 0, 12'h010, 32'hFFFFFFFF, 1, 32'h0,        1));
    vecs.push_back(mk(1, 2, 0, 12'h012, 32'hFFFFFFFF, 1, 32'h0,        1));
    vecs.push_back(mk(0, 2, 1, 12'h010, 32'h0,        0, 32'h1234BE77, 2));
    vecs.push_back(mk(1, 2, 0, 12'h020, 32'h11223344, 0, 32'h0,        3));
    vecs.push_back(mk(0, 1, 1, 12'h012, 32'h0,        0, 32'h00001234, 2));
    vecs.push_back(mk(0, 1, 0, 12'h010, 32'h0,        0, 32'hFFFFBE77, 2));
    vecs.push_back(mk(0, 1, 0, 12'h022, 32'h0,        0, 32'h00001122, 2));

    REQ_VALID = 0; REQ_WE = 0; REQ_SIZE = 0; REQ_UNSIGNED = 0; REQ_ADDR = 0; REQ_WDATA = 0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check("reset_ready", 32'(REQ_READY), 32'h1);
    check("reset_valid", 32'(RESP_VALID), 32'h0);
    check("reset_err",   32'(RESP_ERR),   32'h0);
    check("reset_rdata", RESP_RDATA,      32'h0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              g_err, g_rd, g_lat);
      model_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                m_err, m_rd, m_lat);
      check($sformatf("vec%0d_err", i),   32'(g_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), g_rd,       vecs[i].exp_rdata);
      check($sformatf("vec%0d_lat", i),   32'(g_lat), 32'(vecs[i].exp_lat));
    end

    // Back-to-back loads with REQ_VALID held high.
    wait_ready();
    drive(0, 2, 0, 12'h010, 32'h0);
    @(posedge CLK); #1;
    check("b2b_ready_c1", 32'(REQ_READY), 32'h0);
    REQ_ADDR = 12'h020;
    @(posedge CLK); #1;
    check("b2b_ready_c2", 32'(REQ_READY), 32'h0);
    check("b2b_early",    32'(RESP_VALID), 32'h0);
    @(posedge CLK); #1;
    check("b2b_valid1", 32'(RESP_VALID), 32'h1);
    check("b2b_rdata1", RESP_RDATA, 32'h1234BE77);
    check("b2b_ready_resp", 32'(REQ_READY), 32'h1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("b2b_accept2", 32'(REQ_READY), 32'h0);
    check("b2b_pulse1",  32'(RESP_VALID), 32'h0);
    @(posedge CLK); #1;
    check("b2b_ready_c4", 32'(REQ_READY), 32'h0);
    @(posedge CLK); #1;
    check("b2b_valid2", 32'(RESP_VALID), 32'h1);
    check("b2b_rdata2", RESP_RDATA, 32'h11223344);
    $display("txn back-to-back lw@010 then lw@020 done");

    // Reset at the write edge of a byte store: no response, memory unchanged.
    wait_ready();
    drive(1, 0, 0, 12'h020, 32'h000000AA);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    check("rst_nv1", 32'(RESP_VALID), 32'h0);
    @(posedge CLK); #1;
    check("rst_nv2", 32'(RESP_VALID), 32'h0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_no_resp", 32'(RESP_VALID), 32'h0);
    check("rst_ready",   32'(REQ_READY),  32'h1);
    $display("txn sb@020 aborted by reset");
    run_txn(0, 2, 0, 12'h020, 32'h0, g_err, g_rd, g_lat);
    check("rst_mem_kept", g_rd, 32'h11223344);
    check("rst_mem_lat",  32'(g_lat), 32'h2);

    // Random traffic against the byte-level model.
    for (int n = 0; n < 300; n++) begin
      logic        r_we, r_uns;
      logic [1:0]  r_size;
      logic [11:0] r_addr;
      logic [31:0] r_wdata;
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 63)) : 12'($urandom);
      r_wdata = $urandom;
      run_txn(r_we, r_size, r_uns, r_addr, r_wdata, g_err, g_rd, g_lat);
      model_txn(r_we, r_size, r_uns, r_addr, r_wdata, m_err, m_rd, m_lat);
      check($sformatf("rnd%0d_err", n),   32'(g_err), 32'(m_err));
      check($sformatf("rnd%0d_rdata", n), g_rd,       m_rd);
      check($sformatf("rnd%0d_lat", n),   32'(g_lat), 32'(m_lat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the executer's load/store path: accepts one memory request at a time and returns a single response.
- Request carries address, size, sign mode and store data.
- Wraps a single-port, word-wide synchronous RAM that has no byte enables.
- Byte/halfword stores are done as read-modify-write; loads are lane-extracted and sign/zero-extended before return.

Parameters:
ADDR_WIDTH, 12, byte-address width; RAM depth = 2**(ADDR_WIDTH-2) 32-bit words
INIT_ZERO, 1, 1 = RAM contents zeroed at elaboration (simulation only; reset never clears RAM)

Ports:
CLK  input  1  single clock, all logic on posedge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  1  request present
REQ_READY  output  1  responder can accept a request this cycle
REQ_WE  input  1  1 = store, 0 = load
REQ_SIZE  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
REQ_UNSIGNED  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend
REQ_ADDR  input  ADDR_WIDTH  byte address, little-endian
REQ_WDATA  input  32  store data; low byte/half used for sb/sh
RESP_VALID  output  1  one-cycle pulse: request completed
RESP_RDATA  output  32  load result; 0 for stores and errors
RESP_ERR  output  1  valid with RESP_VALID: misaligned or illegal size

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high. RST has priority over every other event.
- Reset values:
  - state IDLE
  - REQ_READY = 1 (combinational from IDLE)
  - RESP_VALID = 0, RESP_RDATA = 0, RESP_ERR = 0
  - RAM contents untouched
- Accept: handshake completes at edge E when REQ_VALID && REQ_READY.
  - Address, size, we, unsigned flag and wdata are registered at E.
  - Inputs are ignored while REQ_READY = 0.
- REQ_READY = (state == IDLE). No backpressure on the response side.
- Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
- Error check at accept. An error is any of:
  - REQ_SIZE == 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - On error: state goes to ERR, no RAM access; RESP_VALID = 1, RESP_ERR = 1, RESP_RDATA = 0 after edge E+1.
- FSM states:
  - IDLE
  - RD: RAM read issued with the registered index
  - LD: load data is formatted
  - MRG: merged word is written
  - ERR
- Transitions:
  - IDLE -> RD (legal accept) or ERR (illegal accept)
  - RD -> LD (load) or MRG (store)
  - LD -> IDLE
  - MRG -> IDLE
  - ERR -> IDLE
- Latency from accept edge E; RESP_VALID is high for exactly one cycle:
  - load: RESP_VALID high after edge E+2
  - store: RESP_VALID high after edge E+3; the RAM write happens at edge E+3
  - error: RESP_VALID high after edge E+1
- Return to IDLE happens on the same edge that raises RESP_VALID. A new request can therefore be accepted in the cycle RESP_VALID is high. Maximum throughput: one load per 2 cycles, one store per 3 cycles.
- Load formatting:
  - byte = word[8*lane +: 8]
  - half = word[16*lane[1] +: 16]
  - word = unchanged
  - Extension per REQ_UNSIGNED; REQ_UNSIGNED is ignored for word loads.
- Store merge:
  - Only the addressed byte/half lanes are replaced with REQ_WDATA[7:0] / [15:0].
  - Other lanes keep the read value.
  - A word store writes REQ_WDATA unmodified; it still takes the RD cycle, for uniform latency.
- Stores return RESP_RDATA = 0, RESP_ERR = 0.
- Reset mid-operation:
  - RST asserted in any non-IDLE state returns the FSM to IDLE with no response.
  - RST asserted at the MRG edge suppresses the RAM write; the word keeps its old value.
- Addresses wrap naturally within ADDR_WIDTH; no out-of-range error.

Test Plan:
- Store then load: sw 0xDEADBEEF @0x010, then lw @0x010 -> store RESP_VALID 3 cycles after accept, ERR=0; load RESP_RDATA=0xDEADBEEF 2 cycles after accept.
- Byte loads: after the word above, lb @0x011 -> 0xFFFFFFBE; lbu @0x011 -> 0x000000BE; lb @0x013 -> 0xFFFFFFDE.
- Half store merge: sh 0x00001234 @0x012, then lw @0x010 -> 0x1234BEEF. Then sb 0x77 @0x010, lw @0x010 -> 0x1234BE77.
- Misalignment: lw @0x013 -> RESP_VALID + RESP_ERR=1, RDATA=0, 1 cycle after accept, RAM unchanged. Repeat for lh @0x011 and for size=3 -> same error response.
- Back-to-back: hold REQ_VALID high with two loads -> second accepted in the same cycle as the first RESP_VALID; REQ_READY low exactly 2 cycles per load.
- Reset mid-store: sb 0xAA @0x020 (word previously 0x11223344), RST asserted at the MRG edge -> no RESP_VALID, REQ_READY=1 next cycle, lw @0x020 returns 0x11223344.
